// File: rtl/mips_defs.sv
// Shared MIPS definitions: CP0 register numbers, exception codes, field positions
// and the exception entry address used by the next-PC logic.
package mips_defs;

   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   localparam logic [4:0] EXC_INT     = 5'd0;
   localparam logic [4:0] EXC_ADEL    = 5'd4;
   localparam logic [4:0] EXC_ADES    = 5'd5;
   localparam logic [4:0] EXC_SYSCALL = 5'd8;
   localparam logic [4:0] EXC_RI      = 5'd10;
   localparam logic [4:0] EXC_OV      = 5'd12;

   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

   localparam int SR_IE    = 0;
   localparam int SR_EXL   = 1;
   localparam int IM_LO    = 10;
   localparam int IM_HI    = 15;
   localparam int IP_LO    = 10;
   localparam int IP_HI    = 15;
   localparam int EXC_LO   = 2;
   localparam int EXC_HI   = 6;
   localparam int CAUSE_BD = 31;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Trap decision for the instruction in M: masked interrupt vs. pipeline exception,
// interrupts first; both are blocked while a handler is running (EXL).
module cp0_exc_arbiter
   import mips_defs::*;
(
   input  logic [5:0] hw_int,
   input  logic [5:0] im,
   input  logic       ie,
   input  logic       exl,
   input  logic [4:0] exc_code_in,
   output logic       int_req,
   output logic       exc_req,
   output logic       req,
   output logic [4:0] exc_code
);

   assign int_req  = (|(hw_int & im)) & ie & ~exl;
   assign exc_req  = (exc_code_in != EXC_INT) & ~exl;
   assign req      = int_req | exc_req;
   assign exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 in stage M: SR/Cause/EPC/PRId storage, mfc0/mtc0 access and
// the single-cycle trap request that flushes the pipe and redirects fetch.
module cp0_unit
   import mips_defs::*;
#(
   parameter logic [31:0] PRID_VALUE = 32'h0000_2025
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIN,
   input  logic [31:0] PC,
   input  logic [4:0]  ExcCodeIn,
   input  logic        BDIn,
   input  logic [5:0]  HWInt,
   input  logic        en,
   input  logic        EXLClr,
   output logic        Req,
   output logic [31:0] EPCOut,
   output logic [31:0] DOUT
);

   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic        bd;
   logic [5:0]  ip;
   logic [4:0]  exc_code;
   logic [31:0] epc;

   logic        int_req;
   logic        exc_req;
   logic        req;
   logic [4:0]  exc_code_sel;
   logic [31:0] pc_aligned;
   logic [31:0] trap_epc;
   logic [31:0] dout_sel;
   logic        unused_din;

   cp0_exc_arbiter u_arb (
      .hw_int      (HWInt),
      .im          (im),
      .ie          (ie),
      .exl         (exl),
      .exc_code_in (ExcCodeIn),
      .int_req     (int_req),
      .exc_req     (exc_req),
      .req         (req),
      .exc_code    (exc_code_sel)
   );

   // Misaligned fetch (AdEL) still records a word-aligned EPC.
   assign pc_aligned = {PC[31:2], 2'b00};
   assign trap_epc   = BDIn ? (pc_aligned - 32'd4) : pc_aligned;

   always_ff @(posedge clk) begin
      if (reset) begin
         im       <= '0;
         exl      <= 1'b0;
         ie       <= 1'b0;
         bd       <= 1'b0;
         ip       <= '0;
         exc_code <= '0;
         epc      <= '0;
      end else begin
         ip <= HWInt;
         if (req) begin
            exl      <= 1'b1;
            exc_code <= exc_code_sel;
            bd       <= BDIn;
            epc      <= trap_epc;
         end else begin
            if (en && A2 == CP0_SR) begin
               im  <= DIN[IM_HI:IM_LO];
               exl <= DIN[SR_EXL];
               ie  <= DIN[SR_IE];
            end
            if (en && A2 == CP0_EPC)
               epc <= DIN;
            // eret overrides a same-cycle mtc0 on the EXL bit only
            if (EXLClr)
               exl <= 1'b0;
         end
      end
   end

   always_comb begin
      dout_sel = '0;
      case (A1)
         CP0_SR: begin
            dout_sel[IM_HI:IM_LO] = im;
            dout_sel[SR_EXL]      = exl;
            dout_sel[SR_IE]       = ie;
         end
         CP0_CAUSE: begin
            dout_sel[CAUSE_BD]      = bd;
            dout_sel[IP_HI:IP_LO]   = ip;
            dout_sel[EXC_HI:EXC_LO] = exc_code;
         end
         CP0_EPC:  dout_sel = epc;
         CP0_PRID: dout_sel = PRID_VALUE;
         default:  dout_sel = '0;
      endcase
   end

   assign Req    = req & ~reset;
   assign DOUT   = reset ? 32'd0 : dout_sel;
   assign EPCOut = epc;

   assign unused_din = ^{DIN[31:16], DIN[9:2], exc_req};

endmodule

// File: tb/tb_cp0_unit.sv
// Directed test-plan steps followed by random traffic, all checked against a
// word-level CP0 reference model evaluated every cycle.
module tb_cp0_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2, ExcCodeIn;
   logic [31:0] DIN, PC;
   logic        BDIn, en, EXLClr;
   logic [5:0]  HWInt;
   logic        Req;
   logic [31:0] EPCOut, DOUT;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_sr, m_cause, m_epc;
   logic        exp_req, exp_int;
   logic [31:0] exp_dout;

   always #5 clk = ~clk;

   cp0_unit dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIN(DIN), .PC(PC),
      .ExcCodeIn(ExcCodeIn), .BDIn(BDIn), .HWInt(HWInt), .en(en),
      .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .DOUT(DOUT)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Reference: registers kept as full 32-bit words, updated from the register rules.
   function automatic void model_comb();
      exp_int = ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
      exp_req = !reset && (exp_int || (ExcCodeIn != 5'd0 && !m_sr[1]));
      case (A1)
         5'd12:   exp_dout = m_sr;
         5'd13:   exp_dout = m_cause;
         5'd14:   exp_dout = m_epc;
         5'd15:   exp_dout = 32'h0000_2025;
         default: exp_dout = 32'd0;
      endcase
      if (reset) exp_dout = 32'd0;
   endfunction

   function automatic void model_edge();
      if (reset) begin
         m_sr = 0; m_cause = 0; m_epc = 0;
         return;
      end
      if (exp_req) begin
         m_sr[1]       = 1'b1;
         m_cause[31]   = BDIn;
         m_cause[6:2]  = exp_int ? 5'd0 : ExcCodeIn;
         m_epc         = (PC & ~32'd3) - (BDIn ? 32'd4 : 32'd0);
      end else begin
         if (en && A2 == 5'd12) m_sr = DIN & 32'h0000_FC03;
         if (en && A2 == 5'd14) m_epc = DIN;
         if (EXLClr) m_sr[1] = 1'b0;
      end
      m_cause[15:10] = HWInt;
   endfunction

   // Inputs are set at the falling edge; check combinational outputs, then clock.
   task automatic step();
      #1;
      model_comb();
      chk("req", {31'd0, Req}, {31'd0, exp_req});
      chk("dout", DOUT, exp_dout);
      if (!reset) chk("epcout", EPCOut, m_epc);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      A1 = 5'd0; A2 = 5'd0; DIN = 32'd0; PC = 32'h0000_3000; ExcCodeIn = 5'd0;
      BDIn = 1'b0; en = 1'b0; EXLClr = 1'b0; reset = 1'b0;
   endtask

   task automatic peek(input logic [4:0] a, input string tag, input logic [31:0] exp_v);
      A1 = a;
      #1;
      chk(tag, DOUT, exp_v);
   endtask

   logic [4:0] codes [6] = '{5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

   initial begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      idle(); HWInt = 6'd0; reset = 1'b1; A1 = 5'd15;
      step(); step();
      reset = 1'b0;
      peek(5'd12, "rst_sr", 32'd0);
      peek(5'd13, "rst_cause", 32'd0);
      peek(5'd14, "rst_epc", 32'd0);
      peek(5'd15, "prid", 32'h0000_2025);
      chk("rst_req", {31'd0, Req}, 32'd0);
      chk("rst_epcout", EPCOut, 32'd0);

      // Interrupt trap
      en = 1'b1; A2 = 5'd12; DIN = 32'h0000_0401; step();
      idle(); HWInt = 6'b000001; PC = 32'h0000_3010;
      #1 chk("int_req", {31'd0, Req}, 32'd1);
      step();
      peek(5'd13, "int_cause", 32'h0000_0400);
      peek(5'd12, "int_sr", 32'h0000_0403);
      chk("int_epc", EPCOut, 32'h0000_3010);
      chk("int_exl_block", {31'd0, Req}, 32'd0);
      step();

      // Overflow in delay slot
      HWInt = 6'd0; EXLClr = 1'b1; step();
      idle(); ExcCodeIn = 5'd12; BDIn = 1'b1; PC = 32'h0000_3024;
      #1 chk("ov_req", {31'd0, Req}, 32'd1);
      step();
      idle();
      peek(5'd13, "ov_cause", 32'h8000_0030);
      chk("ov_epc", EPCOut, 32'h0000_3020);
      step();

      // Interrupt beats exception
      EXLClr = 1'b1; step();
      idle(); HWInt = 6'b000001; ExcCodeIn = 5'd10; step();
      idle();
      peek(5'd13, "prio_cause", 32'h0000_0400);

      // Trapping mtc0 EPC is suppressed
      HWInt = 6'd0; EXLClr = 1'b1; step();
      idle(); en = 1'b1; A2 = 5'd14; DIN = 32'hDEAD_BEEF; ExcCodeIn = 5'd8; PC = 32'h0000_3040;
      step();
      idle();
      chk("sup_epc", EPCOut, 32'h0000_3040);

      // eret with pending interrupt; Cause write ignored
      HWInt = 6'b000001; EXLClr = 1'b1; en = 1'b1; A2 = 5'd13; DIN = 32'hFFFF_FFFF;
      #1 chk("eret_noreq", {31'd0, Req}, 32'd0);
      step();
      idle();
      peek(5'd13, "cause_ro", 32'h0000_0420);
      chk("eret_int", {31'd0, Req}, 32'd1);
      step();

      // Misaligned fetch still stores an aligned EPC
      idle(); HWInt = 6'd0; EXLClr = 1'b1; step();
      idle(); ExcCodeIn = 5'd4; PC = 32'h0000_3027; step();
      idle();
      chk("adel_epc", EPCOut, 32'h0000_3024);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         reset     = ($urandom_range(0, 49) == 0);
         A1        = 5'($urandom_range(11, 16));
         A2        = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(12, 15));
         DIN       = $urandom;
         PC        = $urandom;
         BDIn      = 1'($urandom);
         en        = 1'($urandom);
         EXLClr    = ($urandom_range(0, 3) == 0);
         HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         ExcCodeIn = ($urandom_range(0, 4) == 0) ? codes[$urandom_range(0, 5)] : 5'd0;
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
